blk_ram_arbiter: RTL
====================

# blk_ram_arbiter

Two-requester round-robin arbiter in front of the single-port block RAM. Accepts read/write commands from requester 0 and requester 1 and issues at most one command per cycle on the RAM READ/WRITE/ADDR/DATAI bus. Returns read data from DATAO to the requester that issued the read. Sits between the requester masters and the RAM slave side, in place of a direct master-to-slave wiring.

## Interface
Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 16, RAM data width
- RD_LAT, 1, RAM read latency in cycles, from the READ cycle to DATAO valid; legal range 1..4

Ports (i = 0, 1; one set per requester):
- CLK  in  1  single clock, rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- EN  in  1  arbitration enable
- REQ_i  in  1  command request; held until ACK_i
- WE_i  in  1  1 = write, 0 = read; stable while REQ_i
- ADDR_i  in  ADDR_W  command address
- WDATA_i  in  DATA_W  write data
- ACK_i  out  1  combinational grant; handshake completes at the edge where REQ_i & ACK_i
- RVALID_i  out  1  read data valid, one-cycle pulse
- RDATA_i  out  DATA_W  read data; valid only with RVALID_i
- READ  out  1  RAM read strobe, registered
- WRITE  out  1  RAM write strobe, registered
- ADDR  out  ADDR_W  RAM address, registered
- DATAI  out  DATA_W  RAM write data, registered
- DATAO  in  DATA_W  RAM read data

## Operation
- Reset values: READ=0, WRITE=0, ADDR=0, DATAI=0, RVALID_i=0, RDATA_i=0, priority pointer PRIO=0, read-tag pipeline cleared.
- ACK_i=0 whenever EN=0 or RST_N=0.
- Grant per cycle, with EN=1:
  - Only one REQ high: that requester is granted.
  - Both REQ high: requester PRIO is granted.
  - After any grant, PRIO becomes the other requester. PRIO is unchanged on cycles with no grant.
- Never both ACK_0 and ACK_1. Never both READ and WRITE.
- Granted command is registered onto the RAM bus for exactly one cycle:
  - WE=1: WRITE=1, ADDR and DATAI from the requester.
  - WE=0: READ=1, ADDR from the requester; DATAI holds its previous value.
- Cycles without a grant: READ=WRITE=0; ADDR and DATAI hold.
- Read return:
  - A tag (valid bit + requester id) enters a RD_LAT+1 deep shift pipeline with each read.
  - When the tag emerges, DATAO is registered into RDATA_id and RVALID_id pulses.
  - The other requester's RDATA holds its value.
- RAM executes commands in issue order. A write followed by a read to the same address returns the new data; no extra hazard logic.
- EN falling: no new grants; reads already in the tag pipeline still return.
- Reset mid-operation: in-flight reads are dropped (no RVALID); all outputs take their reset values immediately.

## Timing
- Handshake cycle C0 → RAM command cycle C1 → DATAO valid at C1+RD_LAT → RVALID_i high in cycle C2+RD_LAT. With RD_LAT=1, RVALID_i is high 3 cycles after C0.
- Throughput: one command per cycle total. Under continuous contention each requester gets 1 per 2 cycles, strictly alternating.
- Back-to-back reads return in issue order with one RVALID per read. No read is ever lost or duplicated.
- ACK depends only on REQ_*, EN and PRIO; no combinational path from DATAO.

## Structure
- Package blk_ram_pkg:
  - ADDR_W and DATA_W defaults.
  - Requester-id typedef (1-bit, REQ0/REQ1).
  - Read-tag struct {valid, id}.
- Sub-module rr_arb2: two-input round-robin grant logic plus the PRIO register.
- Top module holds the RAM command registers, the tag shift pipeline and the return demux.

## Test plan
- Reset: hold RST_N=0 with REQ_0=1 → ACK_0=0, READ=WRITE=0, RVALID_0=RVALID_1=0. Release RST_N → first grant goes to requester 0.
- Single write then read, requester 0: write 16'hA5A5 to addr 8'h10, then read 8'h10 → WRITE pulse with ADDR=8'h10, DATAI=16'hA5A5; RVALID_0 three cycles after the read handshake (RD_LAT=1) with RDATA_0=16'hA5A5; RVALID_1 stays 0.
- Contention: both REQ held high for 6 cycles with distinct addresses → grants alternate 0,1,0,1,0,1; READ high on all 6 command cycles; returns in the same order, each to the correct port.
- Same-address race: requester 1 writes 16'h1234 to 8'h20, requester 0 reads 8'h20 in the next grant cycle → RDATA_0=16'h1234.
- EN drop: issue 2 reads, then deassert EN the following cycle → both RVALIDs still arrive; no ACK while EN=0; PRIO unchanged when EN returns.
- Reset mid-read: assert RST_N low one cycle after a read handshake → no RVALID for that read after reset release; bus idle.

Source files
------------

// File: rtl/blk_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blk_ram_pkg
//  Description : Shared widths, requester id and read-tag types for the
//                block RAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package blk_ram_pkg;

   localparam int unsigned c_addr_w = 8;
   localparam int unsigned c_data_w = 16;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input round-robin grant logic with its priority pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
   import blk_ram_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   req_id_t    r_prio;
   logic [1:0] w_gnt;

   // Requester 0 wins when alone or when it holds priority.
   always_comb begin
      w_gnt = 2'b00;
      if (en && rst_n) begin
         if (req[0] && (!req[1] || r_prio == REQ0)) begin
            w_gnt = 2'b01;
         end else if (req[1]) begin
            w_gnt = 2'b10;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= REQ0;
      end else if (w_gnt[0]) begin
         r_prio <= REQ1;
      end else if (w_gnt[1]) begin
         r_prio <= REQ0;
      end
   end

   assign gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/blk_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : blk_ram_arbiter
//  Description : Round-robin arbiter sharing one single-port block RAM between
//                two requesters, with tagged read-data return.
//  Revision    : 1.0 - initial release
// ============================================================================
module blk_ram_arbiter
   import blk_ram_pkg::*;
#(
   parameter int ADDR_W = c_addr_w,
   parameter int DATA_W = c_data_w,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              req_0,
   input  logic              we_0,
   input  logic [ADDR_W-1:0] addr_0,
   input  logic [DATA_W-1:0] wdata_0,
   output logic              ack_0,
   output logic              rvalid_0,
   output logic [DATA_W-1:0] rdata_0,
   input  logic              req_1,
   input  logic              we_1,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [DATA_W-1:0] wdata_1,
   output logic              ack_1,
   output logic              rvalid_1,
   output logic [DATA_W-1:0] rdata_1,
   output logic              read,
   output logic              write,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] datai,
   input  logic [DATA_W-1:0] datao
);

   logic [1:0]          w_gnt;
   logic                w_gnt_any;
   req_id_t             w_gnt_id;
   logic                w_we;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_wdata;
   rd_tag_t             w_new_tag;
   rd_tag_t             w_ret_tag;

   logic                r_read;
   logic                r_write;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_datai;
   rd_tag_t [RD_LAT:0]  r_tag;
   logic                r_rvalid_0;
   logic                r_rvalid_1;
   logic [DATA_W-1:0]   r_rdata_0;
   logic [DATA_W-1:0]   r_rdata_1;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .req   ({req_1, req_0}),
      .gnt   (w_gnt)
   );

   assign w_gnt_any = |w_gnt;
   assign w_gnt_id  = w_gnt[1] ? REQ1 : REQ0;

   always_comb begin
      w_we      = (w_gnt_id == REQ1) ? we_1    : we_0;
      w_addr    = (w_gnt_id == REQ1) ? addr_1  : addr_0;
      w_wdata   = (w_gnt_id == REQ1) ? wdata_1 : wdata_0;
      w_new_tag = '{valid: w_gnt_any & ~w_we, id: w_gnt_id};
   end

   // The tag reaches the last stage in the cycle DATAO carries its data.
   assign w_ret_tag = r_tag[RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_read     <= 1'b0;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_datai    <= '0;
         r_tag      <= '0;
         r_rvalid_0 <= 1'b0;
         r_rvalid_1 <= 1'b0;
         r_rdata_0  <= '0;
         r_rdata_1  <= '0;
      end else begin
         r_read  <= w_gnt_any & ~w_we;
         r_write <= w_gnt_any & w_we;
         if (w_gnt_any) begin
            r_addr <= w_addr;
         end
         if (w_gnt_any && w_we) begin
            r_datai <= w_wdata;
         end
         r_tag      <= {r_tag[RD_LAT-1:0], w_new_tag};
         r_rvalid_0 <= w_ret_tag.valid && (w_ret_tag.id == REQ0);
         r_rvalid_1 <= w_ret_tag.valid && (w_ret_tag.id == REQ1);
         if (w_ret_tag.valid && w_ret_tag.id == REQ0) begin
            r_rdata_0 <= datao;
         end
         if (w_ret_tag.valid && w_ret_tag.id == REQ1) begin
            r_rdata_1 <= datao;
         end
      end
   end

   assign ack_0    = w_gnt[0];
   assign ack_1    = w_gnt[1];
   assign read     = r_read;
   assign write    = r_write;
   assign addr     = r_addr;
   assign datai    = r_datai;
   assign rvalid_0 = r_rvalid_0;
   assign rvalid_1 = r_rvalid_1;
   assign rdata_0  = r_rdata_0;
   assign rdata_1  = r_rdata_1;

endmodule
`default_nettype wire
